// File: rtl/count_mon_pkg.sv
// Shared types, default parameters and the expected-value helper for the
// count sequence monitor.
package count_mon_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACQ,
        S_LOCK
    } state_t;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_ERR_W       = 8;
    localparam int DEF_LOCK_CYCLES = 2;

    // Computed at 32 bits; callers truncate to their width, which gives the wrap.
    function automatic logic [31:0] next_count(input logic [31:0] prev, input logic en);
        return prev + {31'd0, en};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; an increment coinciding
// with a clear restarts the count at one.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] MAX = '1;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (inc) begin
            if (clr)
                value <= W'(1);
            else if (value != MAX)
                value <= value + W'(1);
        end else if (clr) begin
            value <= '0;
        end
    end

endmodule

// File: rtl/count_seq_monitor.sv
// Passive checker for an enable-gated counter: locks onto the observed
// sequence and reports every transition breaking count(n+1) = count(n) + en(n).
module count_seq_monitor
    import count_mon_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int ERR_W       = DEF_ERR_W,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] count,
    input  logic             clr_err,
    output logic             locked,
    output logic             err,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_cnt,
    output logic [WIDTH-1:0] first_bad,
    output logic [WIDTH-1:0] first_exp
);

    localparam logic [3:0] LOCK_TGT = 4'(LOCK_CYCLES);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] prev_count;
    logic             prev_en;
    logic [WIDTH-1:0] exp_count;
    logic             match;
    logic             viol;
    logic             run_inc;
    logic             run_clr;
    logic [3:0]       good_run;

    // NOTE: every signal assigned here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        exp_count  = WIDTH'(next_count(32'(prev_count), prev_en));
        match      = (count == exp_count);
        state_next = state;
        run_inc    = 1'b0;
        run_clr    = 1'b0;
        viol       = 1'b0;
        case (state)
            S_IDLE: begin
                state_next = S_ACQ;
                run_clr    = 1'b1;
            end
            S_ACQ: begin
                if (match) begin
                    run_inc = 1'b1;
                    if (good_run + 4'd1 == LOCK_TGT)
                        state_next = S_LOCK;
                end else begin
                    run_clr = 1'b1;
                end
            end
            S_LOCK: begin
                if (!match) begin
                    viol       = 1'b1;
                    state_next = S_ACQ;
                    run_clr    = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            prev_count <= '0;
            prev_en    <= 1'b0;
            locked     <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            first_bad  <= '0;
            first_exp  <= '0;
        end else begin
            state      <= state_next;
            prev_count <= count;
            prev_en    <= en;
            locked     <= (state_next == S_LOCK);
            err        <= viol;
            // A violation outranks a simultaneous clear and re-arms the capture.
            if (viol) begin
                err_sticky <= 1'b1;
                if (!err_sticky || clr_err) begin
                    first_bad <= count;
                    first_exp <= exp_count;
                end
            end else if (clr_err) begin
                err_sticky <= 1'b0;
                first_bad  <= '0;
                first_exp  <= '0;
            end
        end
    end

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_err),
        .inc   (viol),
        .value (err_cnt)
    );

    sat_counter #(.W(4)) u_good_run (
        .clk   (clk),
        .rst   (rst),
        .clr   (run_clr),
        .inc   (run_inc),
        .value (good_run)
    );

endmodule

// File: tb/tb_count_seq_monitor.sv
// Directed bench for count_seq_monitor: a sample-history model checked every
// cycle, plus hand-computed literal expectations at the interesting points.
module tb_count_seq_monitor;

    localparam int WIDTH = 8;
    localparam int ERR_W = 8;
    localparam int LOCK  = 2;

    logic             clk;
    logic             rst;
    logic             en;
    logic [WIDTH-1:0] count;
    logic             clr_err;
    logic             locked;
    logic             err;
    logic             err_sticky;
    logic [ERR_W-1:0] err_cnt;
    logic [WIDTH-1:0] first_bad;
    logic [WIDTH-1:0] first_exp;

    int checks = 0;
    int errors = 0;

    count_seq_monitor #(.WIDTH(WIDTH), .ERR_W(ERR_W), .LOCK_CYCLES(LOCK)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .count      (count),
        .clr_err    (clr_err),
        .locked     (locked),
        .err        (err),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt),
        .first_bad  (first_bad),
        .first_exp  (first_exp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Model state: history since reset summarised as the previous sample,
    // the length of the current run of correct transitions and the stats.
    bit primed = 0;
    int m_prev_c = 0;
    int m_prev_en = 0;
    int m_run = 0;
    bit m_locked = 0;
    bit m_err = 0;
    bit m_sticky = 0;
    int m_cnt = 0;
    int m_fb = 0;
    int m_fe = 0;

    always @(posedge clk) begin
        int expect_v;
        bit bad;
        if (rst) begin
            primed = 0; m_prev_c = 0; m_prev_en = 0; m_run = 0;
            m_locked = 0; m_err = 0; m_sticky = 0; m_cnt = 0; m_fb = 0; m_fe = 0;
        end else begin
            expect_v = (m_prev_c + m_prev_en) % 256;
            bad = (int'(count) != expect_v);
            m_err = 0;
            if (!primed) begin
                primed = 1;
                m_run = 0;
            end else if (m_locked) begin
                if (bad) begin
                    m_locked = 0;
                    m_run = 0;
                    m_err = 1;
                    if (!m_sticky || clr_err) begin
                        m_fb = int'(count);
                        m_fe = expect_v;
                    end
                    m_cnt = clr_err ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
                    m_sticky = 1;
                end else if (clr_err) begin
                    m_sticky = 0; m_cnt = 0; m_fb = 0; m_fe = 0;
                end
            end else begin
                m_run = bad ? 0 : m_run + 1;
                if (m_run >= LOCK) m_locked = 1;
            end
            if (!m_err && clr_err) begin
                m_sticky = 0; m_cnt = 0; m_fb = 0; m_fe = 0;
            end
            m_prev_c = int'(count);
            m_prev_en = int'(en);
        end
        #1;
        check("locked", int'(locked), int'(m_locked));
        check("err", int'(err), int'(m_err));
        check("err_sticky", int'(err_sticky), int'(m_sticky));
        check("err_cnt", int'(err_cnt), m_cnt);
        check("first_bad", int'(first_bad), m_fb);
        check("first_exp", int'(first_exp), m_fe);
    end

    // Drive one sample before the next rising edge; returns after that edge.
    task automatic step(input bit r, input bit e, input int c, input bit clr);
        rst     = r;
        en      = e;
        count   = WIDTH'(c);
        clr_err = clr;
        @(negedge clk);
    endtask

    task automatic run_up(input int from, input int to);
        for (int v = from; v <= to; v++) step(0, 1, v, 0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; count = '0; clr_err = 1'b0;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("reset_locked", int'(locked), 0);
        check("reset_err_cnt", int'(err_cnt), 0);
        check("reset_first_bad", int'(first_bad), 0);

        // Lock acquisition on 0,0,1,2,3
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        check("acq_not_yet", int'(locked), 0);
        step(0, 1, 1, 0);
        check("lock_after_3rd", int'(locked), 1);
        run_up(2, 3);
        check("lock_err_cnt", int'(err_cnt), 0);

        // Wrap 254 -> 255 -> 0 -> 1
        step(1, 0, 0, 0);
        run_up(252, 254);
        check("wrap_locked_pre", int'(locked), 1);
        step(0, 1, 255, 0);
        step(0, 1, 0, 0);
        check("wrap_no_err", int'(err), 0);
        check("wrap_locked", int'(locked), 1);
        step(0, 1, 1, 0);

        // Inject 13 where 11 is expected, then relock on 14, 15
        step(1, 0, 0, 0);
        run_up(8, 10);
        step(0, 1, 13, 0);
        check("inj_err", int'(err), 1);
        check("inj_cnt", int'(err_cnt), 1);
        check("inj_sticky", int'(err_sticky), 1);
        check("inj_first_bad", int'(first_bad), 13);
        check("inj_first_exp", int'(first_exp), 11);
        check("inj_unlock", int'(locked), 0);
        step(0, 1, 14, 0);
        check("inj_err_one_cycle", int'(err), 0);
        step(0, 1, 15, 0);
        check("relock", int'(locked), 1);

        // en=0 with count changing 5 -> 6
        step(1, 0, 0, 0);
        step(0, 1, 3, 0);
        step(0, 1, 4, 0);
        step(0, 0, 5, 0);
        check("hold_locked", int'(locked), 1);
        step(0, 1, 6, 0);
        check("hold_first_exp", int'(first_exp), 5);
        check("hold_first_bad", int'(first_bad), 6);
        run_up(7, 8);
        step(0, 1, 20, 0);
        check("second_cnt", int'(err_cnt), 2);
        check("second_first_bad", int'(first_bad), 6);
        check("second_first_exp", int'(first_exp), 5);

        // clr_err together with a violation: bad=40, exp=38
        run_up(35, 37);
        step(0, 1, 40, 1);
        check("clrv_cnt", int'(err_cnt), 1);
        check("clrv_sticky", int'(err_sticky), 1);
        check("clrv_first_bad", int'(first_bad), 40);
        check("clrv_first_exp", int'(first_exp), 38);
        run_up(41, 42);
        step(0, 1, 43, 1);
        check("clr_cnt", int'(err_cnt), 0);
        check("clr_sticky", int'(err_sticky), 0);
        check("clr_first_bad", int'(first_bad), 0);
        check("clr_locked", int'(locked), 1);

        // Three violations, then reset while locked
        step(0, 1, 50, 0); run_up(51, 52);
        step(0, 1, 60, 0); run_up(61, 62);
        step(0, 1, 70, 0); run_up(71, 72);
        check("pre_rst_cnt", int'(err_cnt), 3);
        check("pre_rst_locked", int'(locked), 1);
        step(1, 1, 73, 0);
        check("rst_locked", int'(locked), 0);
        check("rst_cnt", int'(err_cnt), 0);
        check("rst_sticky", int'(err_sticky), 0);
        check("rst_first_exp", int'(first_exp), 0);
        step(0, 1, 73, 0);
        step(0, 1, 74, 0);
        check("rst_relock_early", int'(locked), 0);
        step(0, 1, 75, 0);
        check("rst_relock", int'(locked), 1);
        step(0, 1, 76, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
